// File: rtl/pc_fold_binarizer_if.sv
// rtl/pc_fold_binarizer_if.sv - popcount-in / activation-out handshake bundle
interface pc_fold_binarizer_if #(
    parameter int DIM_OUT    = 32,
    parameter int FOLD       = 4,
    parameter int LOG_DIM_IN = 7
);
    localparam int G = DIM_OUT / FOLD;
    localparam int W = LOG_DIM_IN + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [G-1:0][W-1:0]   in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIM_OUT-1:0]    out_vec;

    modport master (
        output in_valid, in_pc, out_ready,
        input  in_ready, out_valid, out_vec
    );

    modport slave (
        input  in_valid, in_pc, out_ready,
        output in_ready, out_valid, out_vec
    );
endinterface

// File: rtl/pc_fold_binarizer.sv
// rtl/pc_fold_binarizer.sv - thresholds folded popcount groups into a registered activation vector
module pc_fold_binarizer #(
    parameter int DIM_IN     = 110,
    parameter int DIM_OUT    = 32,
    parameter int FOLD       = 4,
    parameter int LOG_DIM_IN = 7,
    localparam int FW        = (FOLD > 1) ? $clog2(FOLD) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic [DIM_OUT-1:0][LOG_DIM_IN:0]   thr,
    output logic [FW-1:0]                      fold_idx,
    pc_fold_binarizer_if.slave                 bus
);
    localparam int G = DIM_OUT / FOLD;
    localparam logic [FW-1:0] LAST = FW'(FOLD - 1);

    if (DIM_OUT % FOLD != 0 || (1 << LOG_DIM_IN) < DIM_IN) begin : g_bad_cfg
        $error("pc_fold_binarizer: inconsistent parameters");
    end

    logic [FW-1:0]       fold_q;
    logic [DIM_OUT-1:0]  buf_q;
    logic [DIM_OUT-1:0]  out_vec_q;
    logic                out_valid_q;
    logic [G-1:0]        grp_bits;
    logic [DIM_OUT-1:0]  next_vec;
    logic                accept;
    logic                last;

    assign last         = (fold_q == LAST);
    assign bus.in_ready = !rst && (!last || !out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Constant-index group select keeps every array index static.
    always_comb begin
        grp_bits = '0;
        for (int k = 0; k < FOLD; k++) begin
            if (fold_q == FW'(k)) begin
                for (int j = 0; j < G; j++) begin
                    grp_bits[j] = (bus.in_pc[j] >= thr[k*G + j]);
                end
            end
        end
    end

    always_comb begin
        next_vec = buf_q;
        next_vec[(FOLD-1)*G +: G] = grp_bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fold_q      <= '0;
            buf_q       <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // clear wins over a same-cycle accept, but leaves a finished vector alone.
            if (clear) begin
                fold_q <= '0;
            end else if (accept) begin
                if (last) begin
                    out_vec_q   <= next_vec;
                    out_valid_q <= 1'b1;
                    fold_q      <= '0;
                end else begin
                    for (int k = 0; k < FOLD; k++) begin
                        if (fold_q == FW'(k)) begin
                            buf_q[k*G +: G] <= grp_bits;
                        end
                    end
                    fold_q <= fold_q + FW'(1);
                end
            end
        end
    end

    assign fold_idx      = fold_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
endmodule

// File: tb/tb_pc_fold_binarizer.sv
// tb/tb_pc_fold_binarizer.sv - scoreboard bench for pc_fold_binarizer
module tb_pc_fold_binarizer;
    localparam int DIM_IN     = 110;
    localparam int DIM_OUT    = 32;
    localparam int FOLD       = 4;
    localparam int LOG_DIM_IN = 7;
    localparam int G          = DIM_OUT / FOLD;
    localparam int W          = LOG_DIM_IN + 1;
    localparam int FW         = $clog2(FOLD);

    typedef logic [G-1:0][W-1:0] grp_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       clear = 1'b0;
    logic [DIM_OUT-1:0][W-1:0]  thr;
    logic [FW-1:0]              fold_idx;

    pc_fold_binarizer_if #(.DIM_OUT(DIM_OUT), .FOLD(FOLD), .LOG_DIM_IN(LOG_DIM_IN)) bus ();

    pc_fold_binarizer #(
        .DIM_IN(DIM_IN), .DIM_OUT(DIM_OUT), .FOLD(FOLD), .LOG_DIM_IN(LOG_DIM_IN)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .thr(thr), .fold_idx(fold_idx), .bus(bus)
    );

    always #5 clk = ~clk;

    int                  n_checks = 0;
    int                  n_pass   = 0;
    logic [DIM_OUT-1:0]  sb[$];
    logic [DIM_OUT-1:0]  m_buf = '0;
    int                  m_fold = 0;
    int                  n_out = 0;
    int                  stalls = 0;
    int                  cyc = 0;
    int                  pop_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) chk("out_vec", bus.out_vec, sb.pop_front());
            n_out++;
            pop_cyc.push_back(cyc);
        end
    end

    function automatic grp_t fill(input int v);
        grp_t r;
        for (int j = 0; j < G; j++) r[j] = W'(v);
        return r;
    endfunction

    function automatic grp_t rnd_grp();
        grp_t r;
        for (int j = 0; j < G; j++) r[j] = W'($urandom_range(0, DIM_IN));
        return r;
    endfunction

    task automatic model_accept(input grp_t pc, input bit clr);
        if (clr) begin
            m_fold = 0;
        end else begin
            for (int j = 0; j < G; j++)
                m_buf[m_fold*G + j] = (int'(pc[j]) >= int'(thr[m_fold*G + j]));
            if (m_fold == FOLD - 1) begin
                sb.push_back(m_buf);
                m_fold = 0;
            end else begin
                m_fold++;
            end
        end
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic send(input grp_t pc, input bit clr = 1'b0);
        int waited = 0;
        chk("fold_idx", 64'(fold_idx), 64'(m_fold));
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        clear        = clr;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        else model_accept(pc, clr);
        stalls += waited;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        clear        = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DIM_OUT-1:0] exp1, exp2;
        grp_t g;
        int n0, s0, p0;

        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        for (int n = 0; n < DIM_OUT; n++) thr[n] = W'(55);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_vec", 64'(bus.out_vec), 64'd0);
        chk("rst_fold", 64'(fold_idx), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        // basic: 56 / 55 / 54 / 110 against thr 55
        bus.out_ready = 1'b1;
        send(fill(56)); send(fill(55)); send(fill(54)); send(fill(110));
        chk("t1_fold_wrap", 64'(fold_idx), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_vec", 64'(bus.out_vec), 64'hFF00_FFFF);
        idle(1);
        chk("t1_pulse", 64'(bus.out_valid), 64'd0);

        // threshold edges
        for (int n = 0; n < DIM_OUT; n++) thr[n] = W'(1);
        thr[0] = W'(0); thr[1] = W'(111); thr[2] = W'(110);
        g = fill(0); g[1] = W'(110); g[2] = W'(110);
        send(g); send(fill(0)); send(fill(0)); send(fill(0));
        @(negedge clk);
        chk("t2_vec", 64'(bus.out_vec), 64'h5);
        idle(1);

        // backpressure
        for (int n = 0; n < DIM_OUT; n++) thr[n] = W'($urandom_range(0, DIM_IN + 1));
        for (int k = 0; k < FOLD; k++) send(rnd_grp());
        exp1 = sb[$];
        bus.out_ready = 1'b0;
        s0 = stalls;
        for (int k = 0; k < FOLD - 1; k++) send(rnd_grp());
        chk("bp_no_stall", 64'(stalls - s0), 64'd0);
        chk("bp_fold", 64'(fold_idx), 64'(FOLD - 1));
        g = rnd_grp();
        bus.in_valid = 1'b1;
        bus.in_pc    = g;
        @(negedge clk);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_hold_vec", 64'(bus.out_vec), 64'(exp1));
        @(posedge clk); #1;
        chk("bp_hold_vec2", 64'(bus.out_vec), 64'(exp1));
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'(bus.in_ready), 64'd1);
        model_accept(g, 1'b0);
        exp2 = sb[$];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_reload_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_reload_vec", 64'(bus.out_vec), 64'(exp2));
        idle(1);

        // streaming
        for (int n = 0; n < DIM_OUT; n++) thr[n] = W'($urandom_range(0, DIM_IN + 1));
        n0 = n_out; s0 = stalls; p0 = pop_cyc.size();
        for (int v = 0; v < 8; v++)
            for (int k = 0; k < FOLD; k++) send(rnd_grp());
        idle(3);
        chk("stream_count", 64'(n_out - n0), 64'd8);
        chk("stream_stalls", 64'(stalls - s0), 64'd0);
        for (int i = 1; i < 8; i++)
            chk("stream_gap", 64'(pop_cyc[p0+i] - pop_cyc[p0+i-1]), 64'(FOLD));

        // clear mid-vector, then clear on the final group
        for (int n = 0; n < DIM_OUT; n++) thr[n] = W'(50);
        send(fill(110)); send(fill(110)); send(fill(110), 1'b1);
        chk("clr_fold", 64'(fold_idx), 64'd0);
        send(fill(10)); send(fill(10)); send(fill(110)); send(fill(10));
        @(negedge clk);
        chk("clr_vec", 64'(bus.out_vec), 64'h00FF_0000);
        idle(1);
        n0 = n_out;
        send(fill(110)); send(fill(110)); send(fill(110)); send(fill(110), 1'b1);
        chk("clr_last_valid", 64'(bus.out_valid), 64'd0);
        chk("clr_last_fold", 64'(fold_idx), 64'd0);
        idle(3);
        chk("clr_last_count", 64'(n_out - n0), 64'd0);

        // reset mid-operation with a pending vector
        for (int k = 0; k < FOLD; k++) send(rnd_grp());
        bus.out_ready = 1'b0;
        send(rnd_grp()); send(rnd_grp());
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_vec", 64'(bus.out_vec), 64'd0);
        chk("mid_rst_fold", 64'(fold_idx), 64'd0);
        chk("mid_rst_in_ready2", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        sb.delete();
        m_fold = 0;
        bus.out_ready = 1'b1;
        n0 = n_out;
        for (int k = 0; k < FOLD; k++) send(rnd_grp());
        idle(3);
        chk("post_rst_count", 64'(n_out - n0), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
